tx_uart_ext: RTL and testbench

TX_UART_EXT -- requirements
Module: tx_uart_ext

---
 rtl/tx_uart_ext.sv | 197 +++++++++++++++++++
 tb/tb_tx_uart_ext.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_uart_ext.sv
// Buffered UART transmitter: byte FIFO, 5-8 data bits, 1/2 stop bits, break generation.
// Define TX_UART_EXT_PARITY_EN to add even/odd parity; otherwise parity_mode is ignored.
module tx_uart_ext #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid,
  input  logic [7:0]                  tx_data,
  input  logic [DIV_WIDTH-1:0]        div,
  input  logic [1:0]                  data_bits,
  input  logic                        stop2,
  input  logic [1:0]                  parity_mode,
  input  logic                        brk,
  output logic                        tx_out,
  output logic                        ready,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_UART_EXT_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t               r_state;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_level;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [7:0]           r_shift;
  logic [2:0]           r_bit_idx;
  logic [1:0]           r_data_bits;
  logic                 r_stop2, r_stop_idx, r_brk_tail, r_tx;

  logic [DIV_WIDTH-1:0] w_div_m1;
  logic [7:0]           w_rd_data;
  logic                 w_bit_end, w_push, w_pop, w_frame_done, w_last_bit;

  assign w_div_m1     = (div == '0) ? '0 : div - DIV_WIDTH'(1);
  assign w_bit_end    = (r_cnt == '0);
  assign w_rd_data    = r_mem[r_rd_ptr];
  assign w_push       = valid && ready;
  assign w_last_bit   = (r_bit_idx == ({1'b0, r_data_bits} + 3'd4));
  // A finishing stop bit or break tail hands over straight to the next start bit.
  assign w_frame_done = (r_state == STOP && w_bit_end && (!r_stop2 || r_stop_idx)) ||
                        (r_state == BREAK && r_brk_tail && w_bit_end);
  assign w_pop        = (r_state == IDLE || w_frame_done) && !brk && (r_level != '0);

  assign ready  = (r_level != (AW+1)'(FIFO_DEPTH));
  assign busy   = (r_state != IDLE) || (r_level != '0);
  assign level  = r_level;
  assign tx_out = r_tx;

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= tx_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
      else if (!w_push && w_pop) r_level <= r_level - (AW+1)'(1);
    end
  end

`ifdef TX_UART_EXT_PARITY_EN
  logic       r_par_en, r_par_bit;
  logic [7:0] w_mask;
  logic       w_par_xor;

  assign w_mask    = 8'hFF >> (2'd3 - data_bits);
  assign w_par_xor = ^(w_rd_data & w_mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_pop) begin
      r_par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
      r_par_bit <= w_par_xor ^ (parity_mode == 2'b10);
    end
  end
`else
  logic w_unused_parity;
  assign w_unused_parity = ^parity_mode;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_tx        <= 1'b1;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_data_bits <= '0;
      r_stop2     <= 1'b0;
      r_stop_idx  <= 1'b0;
      r_brk_tail  <= 1'b0;
    end else begin
      if (!w_bit_end) r_cnt <= r_cnt - DIV_WIDTH'(1);
      case (r_state)
        IDLE:
          if (brk) begin
            r_state    <= BREAK;
            r_tx       <= 1'b0;
            r_brk_tail <= 1'b0;
          end
        START:
          if (w_bit_end) begin
            r_state   <= DATA;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= '0;
            r_cnt     <= w_div_m1;
          end
        DATA:
          if (w_bit_end) begin
            r_cnt <= w_div_m1;
            if (!w_last_bit) begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
            end
`ifdef TX_UART_EXT_PARITY_EN
            else if (r_par_en) begin
              r_state <= PARITY;
              r_tx    <= r_par_bit;
            end
`endif
            else begin
              r_state    <= STOP;
              r_tx       <= 1'b1;
              r_stop_idx <= 1'b0;
            end
          end
`ifdef TX_UART_EXT_PARITY_EN
        PARITY:
          if (w_bit_end) begin
            r_state    <= STOP;
            r_tx       <= 1'b1;
            r_stop_idx <= 1'b0;
            r_cnt      <= w_div_m1;
          end
`endif
        STOP:
          if (w_bit_end) begin
            if (r_stop2 && !r_stop_idx) begin
              r_stop_idx <= 1'b1;
              r_cnt      <= w_div_m1;
            end else begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
            end
          end
        BREAK:
          if (!r_brk_tail) begin
            if (!brk) begin
              r_brk_tail <= 1'b1;
              r_tx       <= 1'b1;
              r_cnt      <= w_div_m1;
            end
          end else if (w_bit_end) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
          end
        default: r_state <= IDLE;
      endcase
      // Launching a frame overrides whatever the case above chose.
      if (w_pop) begin
        r_state     <= START;
        r_tx        <= 1'b0;
        r_cnt       <= w_div_m1;
        r_shift     <= w_rd_data;
        r_bit_idx   <= '0;
        r_data_bits <= data_bits;
        r_stop2     <= stop2;
        r_stop_idx  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tx_uart_ext.sv
// Self-checking bench for tx_uart_ext: line samples are compared with frames built from UART framing rules.
module tb_tx_uart_ext;

  logic        clk, reset, valid, stop2, brk;
  logic [7:0]  tx_data;
  logic [15:0] div;
  logic [1:0]  data_bits, parity_mode;
  logic        tx_out, ready, busy;
  logic [2:0]  level;

  int   total = 0;
  int   bad   = 0;
  logic trace [$];
  bit   exp_q [$];

  tx_uart_ext #(.FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .valid(valid), .tx_data(tx_data), .div(div),
    .data_bits(data_bits), .stop2(stop2), .parity_mode(parity_mode), .brk(brk),
    .tx_out(tx_out), .ready(ready), .busy(busy), .level(level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) trace.push_back(tx_out);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    int g = 0;
    while (trace.size() < n && g < 5000) begin
      step();
      g++;
    end
    if (trace.size() < n) check("wait_timeout", trace.size(), n);
  endtask

  task automatic add_level(input bit v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Expected line samples for one character, one entry per clock.
  task automatic add_frame(input logic [7:0] b, input int d, input int db, input bit s2,
                           input logic [1:0] pm);
    int e  = (d == 0) ? 1 : d;
    int nb = db + 5;
    add_level(1'b0, e);
    for (int i = 0; i < nb; i++) add_level(b[i], e);
`ifdef TX_UART_EXT_PARITY_EN
    if (pm == 2'b01 || pm == 2'b10) begin
      bit p = 1'b0;
      for (int i = 0; i < nb; i++) p ^= b[i];
      if (pm == 2'b10) p = ~p;
      add_level(p, e);
    end
`endif
    add_level(1'b1, s2 ? 2 * e : e);
  endtask

  task automatic compare_trace(input string tag, input int t0);
    int mism = 0;
    wait_to(t0 + exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (trace[t0 + i] !== exp_q[i]) mism++;
    check(tag, mism, 0);
    exp_q.delete();
  endtask

  initial begin
    int t0;
    logic [7:0] bytes [6];
    reset = 1'b1; valid = 1'b0; brk = 1'b0; tx_data = '0;
    div = 16'd4; data_bits = 2'd3; stop2 = 1'b0; parity_mode = 2'b00;
    #2;
    check("rst_tx", tx_out, 1);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 1);
    step(); step();
    reset = 1'b0;
    step();

    // 8N1 0x55 at div 4
    valid = 1'b1; tx_data = 8'h55;
    step();
    valid = 1'b0;
    t0 = trace.size();
    step();
    check("busy_mid", busy, 1);
    add_level(1'b1, 1);
    add_frame(8'h55, 4, 3, 1'b0, 2'b00);
    compare_trace("frame_55", t0);
    check("busy_after_55", busy, 0);

    // 7 bits, even parity, two stop bits
    div = 16'd3; data_bits = 2'd2; parity_mode = 2'b01; stop2 = 1'b1;
    valid = 1'b1; tx_data = 8'h83;
    step();
    valid = 1'b0;
    t0 = trace.size();
    add_level(1'b1, 1);
    add_frame(8'h83, 3, 2, 1'b1, 2'b01);
    compare_trace("frame_83", t0);
    check("busy_after_83", busy, 0);

    // Length change during the 3rd data bit only affects the next frame
    div = 16'd2; data_bits = 2'd3; parity_mode = 2'b00; stop2 = 1'b0;
    valid = 1'b1; tx_data = 8'hC6;
    step();
    t0 = trace.size();
    tx_data = 8'h3B;
    step();
    valid = 1'b0;
    wait_to(t0 + 2 + 3 * 2);
    data_bits = 2'd0;
    add_level(1'b1, 1);
    add_frame(8'hC6, 2, 3, 1'b0, 2'b00);
    add_frame(8'h3B, 2, 0, 1'b0, 2'b00);
    compare_trace("cfg_change", t0);
    data_bits = 2'd3;

    // Fill the FIFO behind a frame in flight; extra pushes are dropped
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99, 8'hEE};
    valid = 1'b1; tx_data = 8'hA0;
    step();
    t0 = trace.size();
    for (int i = 0; i < 6; i++) begin
      tx_data = bytes[i];
      step();
      if (i == 3) begin
        check("full_level", level, 4);
        check("full_ready", ready, 0);
      end
    end
    valid = 1'b0;
    check("drop_level", level, 4);
    add_level(1'b1, 1);
    add_frame(8'hA0, 2, 3, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) add_frame(bytes[i], 2, 3, 1'b0, 2'b00);
    compare_trace("fifo_full", t0);
    check("full_drain_level", level, 0);
    check("full_drain_busy", busy, 0);

    // Break for 50 clocks with a byte queued
    div = 16'd5;
    brk = 1'b1; valid = 1'b1; tx_data = 8'h5A;
    step();
    valid = 1'b0;
    t0 = trace.size();
    check("brk_level", level, 1);
    repeat (49) step();
    brk = 1'b0;
    add_level(1'b0, 50);
    add_level(1'b1, 5);
    add_frame(8'h5A, 5, 3, 1'b0, 2'b00);
    compare_trace("break", t0);

    // Reset mid-frame with three bytes queued
    div = 16'd3;
    valid = 1'b1; tx_data = 8'h0F;
    step();
    tx_data = 8'h10; step();
    tx_data = 8'h20; step();
    tx_data = 8'h30; step();
    valid = 1'b0;
    check("pre_rst_level", level, 3);
    step(); step();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_tx", tx_out, 1);
    check("mid_rst_level", level, 0);
    check("mid_rst_busy", busy, 0);
    step();
    reset = 1'b0;
    step();
    valid = 1'b1; tx_data = 8'hA5;
    step();
    valid = 1'b0;
    t0 = trace.size();
    add_level(1'b1, 1);
    add_frame(8'hA5, 3, 3, 1'b0, 2'b00);
    compare_trace("post_rst", t0);

    // Randomized bursts under random framing
    for (int it = 0; it < 10; it++) begin
      int d, k;
      logic [7:0] b;
      d = $urandom_range(0, 4);
      k = $urandom_range(1, 4);
      div = 16'(d);
      data_bits = 2'($urandom_range(0, 3));
      stop2 = 1'($urandom_range(0, 1));
      parity_mode = 2'($urandom_range(0, 3));
      add_level(1'b1, 1);
      b = 8'($urandom);
      valid = 1'b1; tx_data = b;
      add_frame(b, d, int'(data_bits), stop2, parity_mode);
      step();
      t0 = trace.size();
      for (int j = 1; j < k; j++) begin
        b = 8'($urandom);
        tx_data = b;
        add_frame(b, d, int'(data_bits), stop2, parity_mode);
        step();
      end
      valid = 1'b0;
      check($sformatf("rnd%0d_level", it), level, (k == 1) ? 1 : k - 1);
      compare_trace($sformatf("rnd%0d_wave", it), t0);
      check($sformatf("rnd%0d_busy", it), busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
